// File: rtl/sram_port_arbiter.sv
// Two-port SRAM arbiter: a byte-wide CPU and a Wishbone classic host share
// one write port (port 0) and one read port (port 1). Each port is
// arbitrated on its own, and a starvation counter protects the host.
module sram_port_arbiter #(
   parameter int AW         = 10,
   parameter int STARVE_LIM = 8
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   // CPU side
   input  logic [AW-1:0] cpu_waddr,
   input  logic [7:0]    cpu_wdata,
   input  logic          cpu_wen,
   input  logic [AW-1:0] cpu_raddr,
   input  logic          cpu_ren,
   output logic [7:0]    cpu_rdata,
   output logic          cpu_stall,
   input  logic          host_prio,
   // Wishbone host slave
   input  logic [31:0]   wbh_adr_i,
   input  logic [31:0]   wbh_dat_i,
   input  logic [3:0]    wbh_sel_i,
   input  logic          wbh_we_i,
   input  logic          wbh_stb_i,
   input  logic          wbh_cyc_i,
   output logic [31:0]   wbh_dat_o,
   output logic          wbh_ack_o,
   // SRAM write port
   output logic          sram_csb0,
   output logic [3:0]    sram_wmask0,
   output logic [AW-3:0] sram_addr0,
   output logic [31:0]   sram_din0,
   // SRAM read port
   output logic          sram_csb1,
   output logic [AW-3:0] sram_addr1,
   input  logic [31:0]   sram_dout1
);

   localparam int CW = $clog2(STARVE_LIM + 1);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_ACK} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   starve_q, starve_d;
   logic [31:0]     dat_q, dat_d;
   logic [1:0]      lane_q;
   logic [AW-3:0]   addr0_q, addr0_d, addr1_q, addr1_d;
   logic [3:0]      wmask0_q, wmask0_d;
   logic [31:0]     din0_q, din0_d;

   logic host_req, host_wins, hw_req, hr_req, cw_req, cr_req;
   logic host_wgnt, host_rgnt, cpu_wgnt, cpu_rgnt, host_gnt;
   logic unused_adr;

   // Only word-address bits of the host address reach the SRAM.
   assign unused_adr = ^{wbh_adr_i[31:AW], wbh_adr_i[1:0]};

   // Per-port grant decision; everything is masked while reset is held.
   always_comb begin
      host_req  = (state_q == S_IDLE) & wbh_stb_i & wbh_cyc_i & ~wb_rst_i;
      host_wins = host_prio | (starve_q == CW'(STARVE_LIM));
      hw_req    = host_req & wbh_we_i;
      hr_req    = host_req & ~wbh_we_i;
      cw_req    = cpu_wen & ~wb_rst_i;
      cr_req    = cpu_ren & ~wb_rst_i;
      host_wgnt = hw_req & (~cw_req | host_wins);
      host_rgnt = hr_req & (~cr_req | host_wins);
      cpu_wgnt  = cw_req & ~host_wgnt;
      cpu_rgnt  = cr_req & ~host_rgnt;
      host_gnt  = host_wgnt | host_rgnt;
   end

   assign cpu_stall = (cw_req & ~cpu_wgnt) | (cr_req & ~cpu_rgnt);
   assign sram_csb0 = ~(cpu_wgnt | host_wgnt);
   assign sram_csb1 = ~(cpu_rgnt | host_rgnt);

   // Port address/data muxes; ungranted ports replay their last values.
   always_comb begin
      addr0_d  = addr0_q;
      wmask0_d = wmask0_q;
      din0_d   = din0_q;
      addr1_d  = addr1_q;
      if (cpu_wgnt) begin
         addr0_d  = cpu_waddr[AW-1:2];
         wmask0_d = 4'b0001 << cpu_waddr[1:0];
         din0_d   = {4{cpu_wdata}};
      end else if (host_wgnt) begin
         addr0_d  = wbh_adr_i[AW-1:2];
         wmask0_d = wbh_sel_i;
         din0_d   = wbh_dat_i;
      end
      if (cpu_rgnt)       addr1_d = cpu_raddr[AW-1:2];
      else if (host_rgnt) addr1_d = wbh_adr_i[AW-1:2];
   end

   assign sram_addr0  = addr0_d;
   assign sram_wmask0 = wmask0_d;
   assign sram_din0   = din0_d;
   assign sram_addr1  = addr1_d;

   // Starvation counter: counts denied host cycles, saturating at the limit.
   always_comb begin
      starve_d = starve_q;
      if (!host_req || host_gnt)              starve_d = '0;
      else if (starve_q != CW'(STARVE_LIM))   starve_d = starve_q + CW'(1);
   end

   // Host FSM: IDLE samples requests, RD captures read data, ACK pulses ack.
   always_comb begin
      state_d = state_q;
      dat_d   = dat_q;
      case (state_q)
         S_IDLE: begin
            if (host_wgnt)      state_d = S_ACK;
            else if (host_rgnt) state_d = S_RD;
         end
         S_RD: begin
            if (!wbh_cyc_i) state_d = S_IDLE;
            else begin
               dat_d   = sram_dout1;
               state_d = S_ACK;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign wbh_ack_o = (state_q == S_ACK) & wbh_cyc_i;
   assign wbh_dat_o = dat_q;
   assign cpu_rdata = sram_dout1[{lane_q, 3'b000} +: 8];

   // State, counter, read lane and port hold registers.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q  <= S_IDLE;
         starve_q <= '0;
         dat_q    <= '0;
         lane_q   <= '0;
         addr0_q  <= '0;
         wmask0_q <= '0;
         din0_q   <= '0;
         addr1_q  <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         dat_q    <= dat_d;
         if (cpu_rgnt) lane_q <= cpu_raddr[1:0];
         addr0_q  <= addr0_d;
         wmask0_q <= wmask0_d;
         din0_q   <= din0_d;
         addr1_q  <= addr1_d;
      end
   end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 10, CPU byte-address width (2^AW bytes = 256 x 32-bit words at default).
REQ-002 SHALL have parameter STARVE_LIM, default 8, consecutive host-denied cycles before the host is forced a grant.
REQ-003 SHALL have one clock; reset is asynchronous and active-high: wb_clk_i in 1, rising-edge clock; wb_rst_i in 1, async active-high reset.
REQ-004 cpu_waddr in AW, CPU byte write address; cpu_wdata in 8, CPU write byte; cpu_wen in 1, CPU write request.
REQ-005 cpu_raddr in AW, CPU byte read address; cpu_ren in 1, CPU read request; cpu_rdata out 8, read byte; cpu_stall out 1, CPU request not granted this cycle.
REQ-006 host_prio in 1, host has priority over CPU when high.
REQ-007 wbh_adr_i in 32, wbh_dat_i in 32, wbh_sel_i in 4, wbh_we_i in 1, wbh_stb_i in 1, wbh_cyc_i in 1: Wishbone classic host slave inputs.
REQ-008 wbh_dat_o out 32, host read data; wbh_ack_o out 1, host cycle acknowledge.
REQ-009 sram_csb0 out 1, sram_wmask0 out 4, sram_addr0 out AW-2, sram_din0 out 32: write port (port 0, web0 tied low outside this block).
REQ-010 sram_csb1 out 1, sram_addr1 out AW-2, sram_dout1 in 32: read port (port 1).

Function
REQ-011 Write port and read port SHALL be arbitrated independently; a CPU read and a host write (or vice versa) in the same cycle are both granted.
REQ-012 On a same-port conflict, winner SHALL be CPU when host_prio=0, host when host_prio=1, except forced host grant per REQ-013.
REQ-013 Starve counter: increments each cycle the host has a pending request (IDLE, stb&cyc) that is denied; saturates at STARVE_LIM; when equal to STARVE_LIM the host wins the next conflict; clears on host grant or host request drop.
REQ-014 cpu_stall SHALL be combinational, high in any cycle cpu_wen or cpu_ren is asserted and the corresponding port is not granted to the CPU.
REQ-015 CPU write grant: sram_addr0=cpu_waddr[AW-1:2], sram_wmask0=4'b0001<<cpu_waddr[1:0], sram_din0={4{cpu_wdata}}, sram_csb0=0.
REQ-016 Host write grant: sram_addr0=wbh_adr_i[AW-1:2], sram_wmask0=wbh_sel_i, sram_din0=wbh_dat_i, sram_csb0=0; wbh_adr_i bits above AW-1 and [1:0] ignored.
REQ-017 CPU read grant: sram_addr1=cpu_raddr[AW-1:2], sram_csb1=0; cpu_raddr[1:0] registered; cpu_rdata = sram_dout1 byte selected by registered lane, valid exactly the cycle after grant.
REQ-018 Host read grant: sram_addr1=wbh_adr_i[AW-1:2], sram_csb1=0.
REQ-019 No grant on a port SHALL drive its csb high; wmask/addr/din then don't-care but SHALL hold last value.
REQ-020 Host FSM states: IDLE, RD, ACK.
REQ-021 IDLE: host request sampled only here; write granted -> ACK; read granted -> RD; denied -> stay IDLE.
REQ-022 RD: register sram_dout1 into wbh_dat_o -> ACK.
REQ-023 ACK: wbh_ack_o=1 for exactly one cycle -> IDLE; write ack 1 cycle after grant, read ack 2 cycles after grant.
REQ-024 If wbh_cyc_i drops in RD or ACK, ack SHALL be suppressed and FSM returns to IDLE; SRAM access already issued is not undone.
REQ-025 wbh_dat_o SHALL hold its value until the next host read completes.

Reset
REQ-026 While wb_rst_i high: FSM=IDLE, starve counter=0, wbh_ack_o=0, wbh_dat_o=0, CPU lane register=0, sram_csb0=sram_csb1=1, no grants, cpu_stall=0.
REQ-027 Reset asserted mid-transaction SHALL abort it with no ack; first request sampled on the first clock edge after deassertion.

Verification
REQ-028 Host write adr=0x10, dat=0xA5A5_1234, sel=4'b0011, no CPU activity -> same cycle csb0=0, addr0=4, wmask0=4'b0011; ack next cycle, single pulse.
REQ-029 CPU read raddr=0x13 while word 4 = 0xDEADBEEF -> csb1=0, addr1=4; next cycle cpu_rdata=0xDE, cpu_stall=0.
REQ-030 CPU write and host write every cycle, host_prio=0 -> host denied 8 cycles, cpu_stall=1 on cycle 9 while host granted, host ack cycle 10, counter back to 0.
REQ-031 Host read word 4 concurrent with CPU write byte 0x20 -> both granted same cycle, wbh_dat_o=0xDEADBEEF with ack 2 cycles later, no stall.
REQ-032 Assert wb_rst_i in RD -> no ack, wbh_dat_o=0, both csb=1; after release a new host write completes normally.
